// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream_source transmitter.
//   - DATA_W_DEF : default width of emitted words and of base/stride
//   - CNT_W_DEF  : default width of the word counter (max length 2^CNT_W-1)
//   - streamState_e : IDLE / RUN / DONE controller states
// -----------------------------------------------------------------------------
package stream_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   // IDLE waits for a start, RUN offers words, DONE is the one-cycle
   // completion state that drives the done pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } streamState_e;

endpackage

// File: rtl/stream_source.sv
// -----------------------------------------------------------------------------
// stream_source
// Programmable stream transmitter feeding the din/din_v/din_r side of a PE
// input FIFO. After an accepted start it emits COUNT words forming the
// arithmetic sequence base, base+stride, base+2*stride, ... (mod 2^DATA_W)
// over a valid/ready handshake, one word per cycle while the sink is ready.
//
// Ports
//   clock      : single clock, everything on posedge
//   reset      : synchronous, active-low
//   io_start   : start pulse, only looked at in IDLE
//   io_abort   : cancel the running stream (RUN only)
//   io_base    : first word, latched on accepted start
//   io_stride  : per-word increment, latched on accepted start
//   io_count   : number of words, latched on accepted start
//   io_dout_r  : sink ready
//   io_dout    : stream word
//   io_dout_v  : stream word valid
//   io_busy    : high while in RUN
//   io_done    : one-cycle pulse after the last word was accepted
// -----------------------------------------------------------------------------
module stream_source
   import stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_abort,
   input  logic [DATA_W-1:0] io_base,
   input  logic [DATA_W-1:0] io_stride,
   input  logic [CNT_W-1:0]  io_count,
   input  logic              io_dout_r,
   output logic [DATA_W-1:0] io_dout,
   output logic              io_dout_v,
   output logic              io_busy,
   output logic              io_done
);

   streamState_e      state_q;
   logic [DATA_W-1:0] dout_q;
   logic              doutV_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] stride_q;
   logic [CNT_W-1:0]  remaining_q;

   logic              transfer;
   logic [DATA_W-1:0] dout_d;
   logic [CNT_W-1:0]  remaining_d;

   // A word moves only when we offer it and the sink takes it. The next word
   // and the decremented count are prepared here so the sequential block
   // only has to pick them up on a transfer. The adder wraps naturally,
   // which gives the modulo-2^DATA_W sequence without extra logic.
   always_comb begin
      transfer    = doutV_q & io_dout_r;
      dout_d      = dout_q + stride_q;
      remaining_d = remaining_q - CNT_W'(1);
   end

   // Controller, word accumulator and remaining counter in one block so every
   // output comes straight from a flop; io_dout_r only ever reaches flop
   // inputs, never io_dout_v directly. done_q defaults low each cycle and is
   // raised only on the edge that enters DONE, which makes it a single-cycle
   // pulse that coincides with the DONE state. In IDLE an asserted abort
   // blocks a simultaneous start, so abort always wins. An abort in RUN
   // returns straight to IDLE without a done pulse; a word handed over on
   // that same edge is simply gone from our side, nothing to undo.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         dout_q      <= '0;
         doutV_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stride_q    <= '0;
         remaining_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (io_start && !io_abort) begin
                  if (io_count != '0) begin
                     dout_q      <= io_base;
                     stride_q    <= io_stride;
                     remaining_q <= io_count;
                     doutV_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= RUN;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            RUN: begin
               if (io_abort) begin
                  doutV_q     <= 1'b0;
                  busy_q      <= 1'b0;
                  remaining_q <= '0;
                  state_q     <= IDLE;
               end else if (transfer) begin
                  dout_q      <= dout_d;
                  remaining_q <= remaining_d;
                  if (remaining_q == CNT_W'(1)) begin
                     doutV_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               doutV_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign io_dout   = dout_q;
   assign io_dout_v = doutV_q;
   assign io_busy   = busy_q;
   assign io_done   = done_q;

endmodule

// File: tb/tb_stream_source.sv
// -----------------------------------------------------------------------------
// tb_stream_source
// Directed bench for stream_source. The stimulus process issues streams and
// pushes the words it expects into expWords; a monitor acting as the sink
// FIFO pops and compares on every handshake, checks that offered words stay
// put while ready is low, and counts done pulses.
// -----------------------------------------------------------------------------
module tb_stream_source;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clock;
   logic          reset;
   logic          io_start;
   logic          io_abort;
   logic [DW-1:0] io_base;
   logic [DW-1:0] io_stride;
   logic [CW-1:0] io_count;
   logic          io_dout_r;
   logic [DW-1:0] io_dout;
   logic          io_dout_v;
   logic          io_busy;
   logic          io_done;

   int            checks = 0;
   int            errors = 0;
   int            cycle = 0;
   logic [DW-1:0] expWords[$];
   int            doneSeen = 0;
   int            doneExp = 0;
   int            xferCount = 0;
   int            firstXferCyc = -1;
   int            lastXferCyc = -1;
   int            lastDoneCyc = -1;
   logic          holdPending = 1'b0;
   logic [DW-1:0] heldWord = '0;
   logic [11:0]   readyPat = 12'b1001_0110_0011;

   stream_source #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .io_start  (io_start),
      .io_abort  (io_abort),
      .io_base   (io_base),
      .io_stride (io_stride),
      .io_count  (io_count),
      .io_dout_r (io_dout_r),
      .io_dout   (io_dout),
      .io_dout_v (io_dout_v),
      .io_busy   (io_busy),
      .io_done   (io_done)
   );

   // 10 ns clock and a cycle counter used to timestamp handshakes.
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cycle++;

   // Sink-side monitor, sampling on the falling edge: a valid&ready seen here
   // is the transfer that happens on the next rising edge.
   always @(negedge clock) begin
      if (reset) begin
         if (holdPending) begin
            checks++;
            if (!(io_dout_v === 1'b1 && io_dout === heldWord)) begin
               errors++;
               $display("[TB] FAIL holdStable: got v=%b word=%h required v=1 word=%h",
                        io_dout_v, io_dout, heldWord);
            end
         end
         if (io_dout_v && io_dout_r) begin
            checks++;
            if (expWords.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpectedWord: got %h required none", io_dout);
            end else begin
               logic [DW-1:0] exp;
               exp = expWords.pop_front();
               if (io_dout !== exp) begin
                  errors++;
                  $display("[TB] FAIL word: got %h required %h", io_dout, exp);
               end
            end
            xferCount++;
            if (firstXferCyc < 0) firstXferCyc = cycle;
            lastXferCyc = cycle;
         end
         if (io_done) begin
            doneSeen++;
            lastDoneCyc = cycle;
         end
      end
      holdPending = reset && io_dout_v && !io_dout_r && !io_abort;
      heldWord    = io_dout;
   end

   // Global guard so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish required finish within 200000ns");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] got,
                              input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Pulses start for one cycle and queues the first nExpect words of the
   // sequence. Returns 1 time unit after the edge that samples the start.
   task automatic applyStimulus(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                                input logic [CW-1:0] count, input int nExpect);
      logic [DW-1:0] w;
      io_base   = base;
      io_stride = stride;
      io_count  = count;
      io_start  = 1'b1;
      w = base;
      for (int i = 0; i < nExpect; i++) begin
         expWords.push_back(w);
         w = w + stride;
      end
      @(posedge clock);
      #1;
      io_start = 1'b0;
   endtask

   // Waits a bounded number of cycles for the done pulse, optionally walking
   // ready through the toggle pattern; a missing pulse is a failure.
   task automatic waitDone(input int budget, input bit toggle);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (toggle) io_dout_r = readyPat[11 - (i % 12)];
         @(posedge clock);
         #1;
         if (io_done) begin
            seen = 1'b1;
            break;
         end
      end
      io_dout_r = 1'b1;
      doneExp++;
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL waitDone: got no done required done within %0d cycles", budget);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      int doneSnap;
      reset     = 1'b0;
      io_start  = 1'b0;
      io_abort  = 1'b0;
      io_base   = '0;
      io_stride = '0;
      io_count  = '0;
      io_dout_r = 1'b1;

      // Reset state
      idleCycles(3);
      checkOutput("rstDout", io_dout, 32'h0);
      checkOutput("rstValid", {31'b0, io_dout_v}, 32'h0);
      checkOutput("rstBusy", {31'b0, io_busy}, 32'h0);
      checkOutput("rstDone", {31'b0, io_done}, 32'h0);
      reset = 1'b1;
      idleCycles(2);

      // 1: 5,8,11,14 back to back, done one cycle after the last word
      $display("[TB] test 1 basic stream");
      xferCount = 0;
      firstXferCyc = -1;
      applyStimulus(32'd5, 32'd3, 16'd4, 4);
      checkOutput("t1FirstValid", {31'b0, io_dout_v}, 32'h1);
      checkOutput("t1FirstWord", io_dout, 32'd5);
      checkOutput("t1Busy", {31'b0, io_busy}, 32'h1);
      waitDone(20, 1'b0);
      @(negedge clock);
      #1;
      checkOutput("t1XferCount", xferCount, 32'd4);
      checkOutput("t1Consecutive", lastXferCyc - firstXferCyc, 32'd3);
      checkOutput("t1DoneLatency", lastDoneCyc - lastXferCyc, 32'd1);
      checkOutput("t1BusyInDone", {31'b0, io_busy}, 32'h0);
      @(posedge clock);
      #1;
      checkOutput("t1DonePulse", {31'b0, io_done}, 32'h0);
      idleCycles(2);

      // 2: same stream with ready toggling
      $display("[TB] test 2 backpressure");
      applyStimulus(32'd5, 32'd3, 16'd4, 4);
      waitDone(40, 1'b1);
      idleCycles(2);

      // 3: zero-length stream
      $display("[TB] test 3 count zero");
      applyStimulus(32'd77, 32'd1, 16'd0, 0);
      doneExp++;
      checkOutput("t3Done", {31'b0, io_done}, 32'h1);
      checkOutput("t3Valid", {31'b0, io_dout_v}, 32'h0);
      checkOutput("t3Busy", {31'b0, io_busy}, 32'h0);
      @(posedge clock);
      #1;
      checkOutput("t3DoneOnce", {31'b0, io_done}, 32'h0);
      checkOutput("t3BusyAfter", {31'b0, io_busy}, 32'h0);
      idleCycles(2);

      // 4: wrap around 2^32
      $display("[TB] test 4 wrap");
      applyStimulus(32'hFFFF_FFFE, 32'd1, 16'd3, 3);
      waitDone(20, 1'b0);
      idleCycles(2);

      // 5: abort after the second transfer of a 5-word stream
      $display("[TB] test 5 abort");
      applyStimulus(32'd10, 32'd2, 16'd5, 2);
      idleCycles(2);
      io_abort  = 1'b1;
      io_dout_r = 1'b0;
      doneSnap  = doneSeen;
      @(posedge clock);
      #1;
      io_abort  = 1'b0;
      io_dout_r = 1'b1;
      checkOutput("t5ValidLow", {31'b0, io_dout_v}, 32'h0);
      checkOutput("t5BusyLow", {31'b0, io_busy}, 32'h0);
      idleCycles(3);
      checkOutput("t5NoDone", doneSeen, doneSnap);
      applyStimulus(32'd20, 32'd5, 16'd2, 2);
      checkOutput("t5Restart", {31'b0, io_dout_v}, 32'h1);
      waitDone(20, 1'b0);
      idleCycles(2);

      // 6: ignored start during RUN, then reset mid-stream
      $display("[TB] test 6 reset mid-stream");
      applyStimulus(32'd100, 32'd7, 16'd6, 3);
      io_base  = 32'd999;
      io_count = 16'd9;
      io_start = 1'b1;
      @(posedge clock);
      #1;
      io_start = 1'b0;
      idleCycles(2);
      checkOutput("t6BusyMid", {31'b0, io_busy}, 32'h1);
      reset     = 1'b0;
      io_dout_r = 1'b0;
      doneSnap  = doneSeen;
      @(posedge clock);
      #1;
      checkOutput("t6RstDout", io_dout, 32'h0);
      checkOutput("t6RstValid", {31'b0, io_dout_v}, 32'h0);
      checkOutput("t6RstBusy", {31'b0, io_busy}, 32'h0);
      reset     = 1'b1;
      io_dout_r = 1'b1;
      idleCycles(3);
      checkOutput("t6NoDone", doneSeen, doneSnap);
      applyStimulus(32'd1, 32'd1, 16'd2, 2);
      waitDone(20, 1'b0);
      idleCycles(3);

      // End-of-run bookkeeping
      checkOutput("queueEmpty", expWords.size(), 32'd0);
      checkOutput("doneCount", doneSeen, doneExp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
